// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: parser state encoding,
// error codes and default framing parameters.
// Ports: none (package).
// Optional feature macro: UART_FRAME_TIMEOUT_EN (used by uart_frame_parser).
package uart_frame_parser_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4
    } state_t;

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [BYTE_W-1:0] HEADER_DEFAULT    = 8'hA5;
    localparam int unsigned       MAX_WORDS_DEFAULT = 16;
    localparam logic [31:0]       TIMEOUT_DEFAULT   = 32'd500000;

endpackage

// File: rtl/uart_word_packer.sv
// Packs payload bytes MSB-first into 32-bit words.
// Ports:
//   clock, rst      - clock, synchronous active-high reset
//   clear           - restart packing at a byte boundary (frame start)
//   shift_en        - shift_byte is a payload byte to consume
//   shift_byte      - payload byte
//   byte_cnt        - bytes already held for the current word (0..3)
//   word_valid      - one-cycle strobe, word_data holds a completed word
//   word_data       - last completed word, first byte in bits [31:24]
module uart_word_packer
    import uart_frame_parser_pkg::*;
(
    input  logic              clock,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] shift_byte,
    output logic [1:0]        byte_cnt,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data
);

    // The three earlier bytes of the word in progress
    logic [WORD_W-BYTE_W-1:0] shift_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            shift_q    <= '0;
            byte_cnt   <= 2'd0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shift_q  <= '0;
                byte_cnt <= 2'd0;
            end else if (shift_en) begin
                shift_q  <= {shift_q[WORD_W-2*BYTE_W-1:0], shift_byte};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word_valid <= 1'b1;
                    word_data  <= {shift_q, shift_byte};
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts framed command packets (header, cmd, len, payload words, XOR
// checksum) from a UART byte stream and streams payload words downstream.
// Optional feature macro: UART_FRAME_TIMEOUT_EN enables an inter-byte idle
// timeout that aborts a stalled frame with err_code 3.
// Ports:
//   clock, rst   - clock, synchronous active-high reset
//   rx_en        - one-cycle strobe, rx_data holds a received byte
//   rx_data      - received byte
//   frame_busy   - high from header accept until frame end
//   frame_cmd    - command byte of the current/last frame
//   frame_len    - word count of the current/last frame
//   word_valid   - one-cycle strobe for word_data/word_idx
//   word_data    - assembled payload word
//   word_idx     - 0-based index of word_data in the frame
//   frame_done   - one-cycle strobe, checksum matched
//   frame_err    - one-cycle strobe, frame aborted
//   err_code     - reason for the last frame_err (1 len, 2 chk, 3 timeout)
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter logic [BYTE_W-1:0] HEADER         = HEADER_DEFAULT,
    parameter int unsigned       MAX_WORDS      = MAX_WORDS_DEFAULT,
    parameter logic [31:0]       TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              rx_en,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              frame_busy,
    output logic [BYTE_W-1:0] frame_cmd,
    output logic [BYTE_W-1:0] frame_len,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic [7:0]        word_idx,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    state_t            state;
    logic [BYTE_W-1:0] chk;
    logic [7:0]        word_cnt;
    logic [1:0]        byte_cnt;
    logic              len_bad_c;
    logic              pack_clear_c;
    logic              pack_shift_c;

    assign len_bad_c    = (rx_data == '0) || (rx_data > BYTE_W'(MAX_WORDS));
    // Packer restarts on header accept and again once the length is known
    assign pack_clear_c = rx_en && (((state == ST_IDLE) && (rx_data == HEADER)) ||
                                    (state == ST_LEN));
    assign pack_shift_c = rx_en && (state == ST_PAYLOAD);

    uart_word_packer u_packer (
        .clock      (clock),
        .rst        (rst),
        .clear      (pack_clear_c),
        .shift_en   (pack_shift_c),
        .shift_byte (rx_data),
        .byte_cnt   (byte_cnt),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

`ifdef UART_FRAME_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // Idle clocks since the last byte while a frame is open
    always_ff @(posedge clock) begin
        if (rst || rx_en || (state == ST_IDLE)) begin
            idle_cnt <= 32'd0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Frame state machine, checksum and registered frame outputs
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= ST_IDLE;
            chk        <= '0;
            word_cnt   <= 8'd0;
            frame_busy <= 1'b0;
            frame_cmd  <= '0;
            frame_len  <= '0;
            word_idx   <= 8'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_en) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == HEADER) begin
                            state      <= ST_CMD;
                            frame_busy <= 1'b1;
                            chk        <= '0;
                        end
                    end
                    ST_CMD: begin
                        frame_cmd <= rx_data;
                        chk       <= chk ^ rx_data;
                        state     <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (len_bad_c) begin
                            frame_err  <= 1'b1;
                            err_code   <= ERR_LEN;
                            frame_busy <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            frame_len <= rx_data;
                            chk       <= chk ^ rx_data;
                            word_cnt  <= 8'd0;
                            state     <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        chk <= chk ^ rx_data;
                        if (byte_cnt == 2'd3) begin
                            word_idx <= word_cnt;
                            word_cnt <= word_cnt + 8'd1;
                            if (word_cnt == frame_len - 8'd1) begin
                                state <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (rx_data == chk) begin
                            frame_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                        end
                        frame_busy <= 1'b0;
                        state      <= ST_IDLE;
                    end
                    default: begin
                        frame_busy <= 1'b0;
                        state      <= ST_IDLE;
                    end
                endcase
`ifdef UART_FRAME_TIMEOUT_EN
            end else if ((state != ST_IDLE) && (idle_cnt == TIMEOUT_CYCLES - 32'd1)) begin
                frame_err  <= 1'b1;
                err_code   <= ERR_TIMEOUT;
                frame_busy <= 1'b0;
                state      <= ST_IDLE;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: a table of bytes with the
// expected registered outputs after each byte, plus hand-written sequences
// for a maximum-length frame, back-to-back strobes, reset mid-frame and the
// idle timeout (behaviour depends on UART_FRAME_TIMEOUT_EN).
module tb_uart_frame_parser;

    logic        clock;
    logic        rst;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic        frame_busy;
    logic [7:0]  frame_cmd;
    logic [7:0]  frame_len;
    logic        word_valid;
    logic [31:0] word_data;
    logic [7:0]  word_idx;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;

    uart_frame_parser #(
        .HEADER         (8'hA5),
        .MAX_WORDS      (16),
        .TIMEOUT_CYCLES (32'd1000)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .rx_en      (rx_en),
        .rx_data    (rx_data),
        .frame_busy (frame_busy),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_idx   (word_idx),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        busy;
        logic [7:0]  cmd;
        logic [7:0]  len;
        logic        wv;
        logic [31:0] wd;
        logic [7:0]  widx;
        logic        done;
        logic        err;
        logic [1:0]  code;
    } obs_t;

    typedef struct {
        logic [7:0] b;
        obs_t       exp;
    } vec_t;

    vec_t vecs[$];

    function automatic obs_t observe();
        return '{frame_busy, frame_cmd, frame_len, word_valid, word_data,
                 word_idx, frame_done, frame_err, err_code};
    endfunction

    function automatic void add(input logic [7:0] b, input logic busy,
                                input logic [7:0] cmd, input logic [7:0] len,
                                input logic wv, input logic [31:0] wd,
                                input logic [7:0] widx, input logic done,
                                input logic err, input logic [1:0] code);
        vec_t v;
        v.b   = b;
        v.exp = '{busy, cmd, len, wv, wd, widx, done, err, code};
        vecs.push_back(v);
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got busy=%b cmd=%h len=%h wv=%b wd=%h idx=%0d done=%b err=%b code=%0d / exp busy=%b cmd=%h len=%h wv=%b wd=%h idx=%0d done=%b err=%b code=%0d",
                     name, got.busy, got.cmd, got.len, got.wv, got.wd, got.widx, got.done, got.err, got.code,
                     exp.busy, exp.cmd, exp.len, exp.wv, exp.wd, exp.widx, exp.done, exp.err, exp.code);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h exp %h", name, got, exp);
        end
    endtask

    // One byte strobe; returns at the following negedge with outputs settled
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        rx_en   = 1'b1;
        rx_data = b;
        @(negedge clock);
        rx_en   = 1'b0;
        rx_data = 8'h00;
    endtask

    // The two abort/accept strobes must never coincide
    always @(negedge clock) begin
        if (frame_done && frame_err) begin
            fails++;
            $display("FAIL done_err_overlap: got both high at %0t", $time);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, exp finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  seq[$];
        logic [7:0]  x;
        logic [31:0] got_w;
        logic [7:0]  got_i;
        logic        got_done;
        logic        got_err;
        int          k;

        rst     = 1'b1;
        rx_en   = 1'b0;
        rx_data = 8'h00;

        // Good frame
        add(8'hA5, 1, 8'h00, 8'h00, 0, 32'h0,        0, 0, 0, 0);
        add(8'h10, 1, 8'h10, 8'h00, 0, 32'h0,        0, 0, 0, 0);
        add(8'h02, 1, 8'h10, 8'h02, 0, 32'h0,        0, 0, 0, 0);
        add(8'h11, 1, 8'h10, 8'h02, 0, 32'h0,        0, 0, 0, 0);
        add(8'h22, 1, 8'h10, 8'h02, 0, 32'h0,        0, 0, 0, 0);
        add(8'h33, 1, 8'h10, 8'h02, 0, 32'h0,        0, 0, 0, 0);
        add(8'h44, 1, 8'h10, 8'h02, 1, 32'h11223344, 0, 0, 0, 0);
        add(8'h55, 1, 8'h10, 8'h02, 0, 32'h11223344, 0, 0, 0, 0);
        add(8'h66, 1, 8'h10, 8'h02, 0, 32'h11223344, 0, 0, 0, 0);
        add(8'h77, 1, 8'h10, 8'h02, 0, 32'h11223344, 0, 0, 0, 0);
        add(8'h88, 1, 8'h10, 8'h02, 1, 32'h55667788, 1, 0, 0, 0);
        add(8'h9A, 0, 8'h10, 8'h02, 0, 32'h55667788, 1, 1, 0, 0);
        // Same frame, wrong checksum
        add(8'hA5, 1, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 0, 0);
        add(8'h10, 1, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 0, 0);
        add(8'h02, 1, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 0, 0);
        add(8'h11, 1, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 0, 0);
        add(8'h22, 1, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 0, 0);
        add(8'h33, 1, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 0, 0);
        add(8'h44, 1, 8'h10, 8'h02, 1, 32'h11223344, 0, 0, 0, 0);
        add(8'h55, 1, 8'h10, 8'h02, 0, 32'h11223344, 0, 0, 0, 0);
        add(8'h66, 1, 8'h10, 8'h02, 0, 32'h11223344, 0, 0, 0, 0);
        add(8'h77, 1, 8'h10, 8'h02, 0, 32'h11223344, 0, 0, 0, 0);
        add(8'h88, 1, 8'h10, 8'h02, 1, 32'h55667788, 1, 0, 0, 0);
        add(8'h9B, 0, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 1, 2);
        // Garbage then a good one-word frame
        add(8'h00, 0, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 0, 2);
        add(8'hFF, 0, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 0, 2);
        add(8'h5A, 0, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 0, 2);
        add(8'hA5, 1, 8'h10, 8'h02, 0, 32'h55667788, 1, 0, 0, 2);
        add(8'h01, 1, 8'h01, 8'h02, 0, 32'h55667788, 1, 0, 0, 2);
        add(8'h01, 1, 8'h01, 8'h01, 0, 32'h55667788, 1, 0, 0, 2);
        add(8'hDE, 1, 8'h01, 8'h01, 0, 32'h55667788, 1, 0, 0, 2);
        add(8'hAD, 1, 8'h01, 8'h01, 0, 32'h55667788, 1, 0, 0, 2);
        add(8'hBE, 1, 8'h01, 8'h01, 0, 32'h55667788, 1, 0, 0, 2);
        add(8'hEF, 1, 8'h01, 8'h01, 1, 32'hDEADBEEF, 0, 0, 0, 2);
        add(8'h22, 0, 8'h01, 8'h01, 0, 32'hDEADBEEF, 0, 1, 0, 2);
        // Length zero, stray byte, length above MAX_WORDS
        add(8'hA5, 1, 8'h01, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 2);
        add(8'h01, 1, 8'h01, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 2);
        add(8'h00, 0, 8'h01, 8'h01, 0, 32'hDEADBEEF, 0, 0, 1, 1);
        add(8'h11, 0, 8'h01, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        add(8'hA5, 1, 8'h01, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        add(8'h01, 1, 8'h01, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        add(8'h11, 0, 8'h01, 8'h01, 0, 32'hDEADBEEF, 0, 0, 1, 1);
        // Header value used as payload data
        add(8'hA5, 1, 8'h01, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        add(8'h02, 1, 8'h02, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        add(8'h01, 1, 8'h02, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        add(8'hA5, 1, 8'h02, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        add(8'hA5, 1, 8'h02, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        add(8'hA5, 1, 8'h02, 8'h01, 0, 32'hDEADBEEF, 0, 0, 0, 1);
        add(8'hA5, 1, 8'h02, 8'h01, 1, 32'hA5A5A5A5, 0, 0, 0, 1);
        add(8'h03, 0, 8'h02, 8'h01, 0, 32'hA5A5A5A5, 0, 1, 0, 1);

        repeat (3) @(negedge clock);
        check_obs("reset_state", observe(), '0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            send(vecs[i].b);
            check_obs($sformatf("vec%0d_byte%h", i, vecs[i].b), observe(), vecs[i].exp);
        end

        // Maximum legal length: 16 words of bytes 0..63
        send(8'hA5);
        send(8'h03);
        send(8'h10);
        x = 8'h03 ^ 8'h10;
        for (int w = 0; w < 16; w++) begin
            for (int j = 0; j < 4; j++) begin
                send(8'(4 * w + j));
                x = x ^ 8'(4 * w + j);
            end
            check_val($sformatf("max_word%0d_valid", w), 32'(word_valid), 32'd1);
            check_val($sformatf("max_word%0d_data", w), word_data,
                      {8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)});
            check_val($sformatf("max_word%0d_idx", w), 32'(word_idx), 32'(w));
        end
        send(x);
        check_val("max_done", {30'd0, frame_done, frame_err}, 32'd2);
        check_val("max_len", 32'(frame_len), 32'd16);

        // Back-to-back strobes: rx_en held high across the whole frame
        seq = '{8'hA5, 8'h05, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        got_w    = 32'h0;
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clock);
            if (word_valid) got_w = word_data;
            if (frame_done) got_done = 1'b1;
            if (frame_err)  got_err = 1'b1;
            rx_en   = 1'b1;
            rx_data = seq[i];
        end
        @(negedge clock);
        rx_en = 1'b0;
        if (word_valid) got_w = word_data;
        if (frame_done) got_done = 1'b1;
        if (frame_err)  got_err = 1'b1;
        check_val("b2b_word", got_w, 32'h01020304);
        check_val("b2b_done_err", {30'd0, got_done, got_err}, 32'd2);
        check_val("b2b_cmd", 32'(frame_cmd), 32'h05);

        // Reset after the second payload byte, then a fresh frame
        send(8'hA5);
        send(8'h01);
        send(8'h01);
        send(8'hDE);
        send(8'hAD);
        rst = 1'b1;
        @(negedge clock);
        check_obs("reset_mid_payload", observe(), '0);
        rst = 1'b0;
        seq = '{8'hA5, 8'h07, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        foreach (seq[i]) send(seq[i]);
        check_obs("after_reset_word", observe(),
                  '{1'b1, 8'h07, 8'h01, 1'b1, 32'hCAFEBABE, 8'd0, 1'b0, 1'b0, 2'd0});
        send(8'h36);
        check_obs("after_reset_done", observe(),
                  '{1'b0, 8'h07, 8'h01, 1'b0, 32'hCAFEBABE, 8'd0, 1'b1, 1'b0, 2'd0});

        // Truncated frame followed by silence
        send(8'hA5);
        send(8'h01);
        send(8'h01);
        send(8'hDE);
        k = 0;
        got_err = 1'b0;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clock);
            if (frame_err && !got_err) begin
                got_err = 1'b1;
                k = c;
                got_i = {6'd0, err_code};
                check_val("timeout_busy", 32'(frame_busy), 32'd0);
            end
        end
`ifdef UART_FRAME_TIMEOUT_EN
        check_val("timeout_seen", 32'(got_err), 32'd1);
        check_val("timeout_cycles", 32'(k), 32'd1000);
        check_val("timeout_code", 32'(got_i), 32'd3);
`else
        check_val("no_timeout_err", 32'(got_err), 32'd0);
        check_val("no_timeout_busy", 32'(frame_busy), 32'd1);
        check_val("no_timeout_code", 32'(err_code), 32'd0);
`endif
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
